// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial stage with valid/ready intake and registered serial output.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    cnt_q;
   logic             x_out_q;
   logic             x_valid_q;
`ifdef PISO_SERIALIZER_PARITY_EN
   logic             parity_q;
`endif

   logic last_bit;
   logic accept;

   always_comb begin
      last_bit = (state_q == SHIFT) && (cnt_q == '0);
`ifdef PISO_SERIALIZER_PARITY_EN
      in_ready = (state_q == IDLE) || (state_q == PARITY);
`else
      in_ready = (state_q == IDLE) || last_bit;
`endif
      accept   = in_valid && in_ready;
   end

   // shift_q holds only the bits still to be presented; the current bit lives in x_out_q.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         x_out_q   <= 1'b0;
         x_valid_q <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else if (accept) begin
         state_q   <= SHIFT;
         shift_q   <= {in_data[WIDTH-2:0], 1'b0};
         cnt_q     <= LAST_IDX;
         x_out_q   <= in_data[WIDTH-1];
         x_valid_q <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
         parity_q  <= ^in_data;
`endif
      end else if ((state_q == SHIFT) && !last_bit) begin
         shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
         cnt_q     <= cnt_q - CW'(1);
         x_out_q   <= shift_q[WIDTH-1];
`ifdef PISO_SERIALIZER_PARITY_EN
      end else if (state_q == SHIFT) begin
         state_q   <= PARITY;
         x_out_q   <= parity_q;
`endif
      end else begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         x_out_q   <= 1'b0;
         x_valid_q <= 1'b0;
      end
   end

   assign x_out   = x_out_q;
   assign x_valid = x_valid_q;
   assign busy    = x_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus randomized traffic
// compared against a queue-of-bits reference model.
module tb_piso_serializer;

   localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
   localparam int PW = W + 1;
`else
   localparam int PW = W;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         x_out;
   logic         x_valid;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Reference model: every bit still to appear on the line, front = bit on the line now.
   bit m_q[$];
   logic m_x, m_v, m_r;

   piso_serializer #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_out    (x_out),
      .x_valid  (x_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] frame(input logic [W-1:0] w);
`ifdef PISO_SERIALIZER_PARITY_EN
      return {w, ^w};
`else
      return w;
`endif
   endfunction

   task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
      logic [PW-1:0] f;
      logic acc;
      in_valid = v;
      in_data  = d;
      reset_n  = r;
      @(posedge clk);
      if (!r) begin
         m_q.delete();
      end else begin
         acc = v && (m_q.size() <= 1);
         if (m_q.size() > 0) void'(m_q.pop_front());
         if (acc) begin
            f = frame(d);
            for (int i = PW - 1; i >= 0; i--) m_q.push_back(f[i]);
         end
      end
      m_v = (m_q.size() > 0);
      m_x = m_v ? m_q[0] : 1'b0;
      m_r = (m_q.size() <= 1);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 8'hC3, 1'b0);
         checks++;
         if ({x_out, x_valid, busy, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state edge%0d: got x_out/x_valid/busy/in_ready=%b required 0001",
                     i, {x_out, x_valid, busy, in_ready});
         end
      end
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if ({x_out, x_valid, busy, in_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_no_accept: got %b required 0001", {x_out, x_valid, busy, in_ready});
      end
      $display("test_reset done");
   endtask

   task automatic test_single(input logic [W-1:0] word);
      logic [PW-1:0] got;
      logic [PW-1:0] vld;
      cycle(1'b1, word, 1'b1);
      for (int k = 0; k < PW; k++) begin
         checks++;
         if ({x_out, x_valid, busy, in_ready} !== {m_x, m_v, m_v, m_r}) begin
            errors++;
            $display("FAIL single_model k=%0d: got %b required %b", k,
                     {x_out, x_valid, busy, in_ready}, {m_x, m_v, m_v, m_r});
         end
         got[PW-1-k] = x_out;
         vld[PW-1-k] = x_valid;
         cycle(1'b0, W'($urandom), 1'b1);
      end
      checks++;
      if (got !== frame(word) || vld !== '1) begin
         errors++;
         $display("FAIL single_bits word=%h: got bits %b valid %b required bits %b valid all 1",
                  word, got, vld, frame(word));
      end
      checks++;
      if ({x_out, x_valid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL single_idle_after: got %b required 000", {x_out, x_valid, busy});
      end
      $display("test_single word=%h bits=%b", word, got);
   endtask

   task automatic test_back_to_back();
      logic [2*PW-1:0] got;
      logic [2*PW-1:0] vld;
      cycle(1'b1, 8'h05, 1'b1);
      for (int k = 0; k < 2 * PW; k++) begin
         checks++;
         if ({x_out, x_valid, busy, in_ready} !== {m_x, m_v, m_v, m_r}) begin
            errors++;
            $display("FAIL b2b_model k=%0d: got %b required %b", k,
                     {x_out, x_valid, busy, in_ready}, {m_x, m_v, m_v, m_r});
         end
         got[2*PW-1-k] = x_out;
         vld[2*PW-1-k] = x_valid;
         cycle(k < PW, (k < PW) ? 8'hA0 : W'($urandom), 1'b1);
      end
      checks++;
      if (got !== {frame(8'h05), frame(8'hA0)} || vld !== '1) begin
         errors++;
         $display("FAIL b2b_bits: got bits %b valid %b required bits %b valid all 1",
                  got, vld, {frame(8'h05), frame(8'hA0)});
      end
      $display("test_back_to_back bits=%b", got);
   endtask

   task automatic test_backpressure();
      logic [W-1:0]  d;
      logic [W-1:0]  taken;
      logic [PW-1:0] got;
      cycle(1'b1, 8'h3C, 1'b1);
      taken = '0;
      for (int k = 0; k < PW; k++) begin
         checks++;
         if (in_ready !== (k == PW - 1)) begin
            errors++;
            $display("FAIL bp_ready k=%0d: got %b required %b", k, in_ready, (k == PW - 1));
         end
         d = W'($urandom);
         if (k == PW - 1) taken = d;
         cycle(1'b1, d, 1'b1);
      end
      for (int j = 0; j < PW; j++) begin
         checks++;
         if ({x_out, x_valid, busy, in_ready} !== {m_x, m_v, m_v, m_r}) begin
            errors++;
            $display("FAIL bp_model j=%0d: got %b required %b", j,
                     {x_out, x_valid, busy, in_ready}, {m_x, m_v, m_v, m_r});
         end
         got[PW-1-j] = x_out;
         cycle(1'b0, W'($urandom), 1'b1);
      end
      checks++;
      if (got !== frame(taken)) begin
         errors++;
         $display("FAIL bp_word: got bits %b required %b", got, frame(taken));
      end
      $display("test_backpressure accepted=%h bits=%b", taken, got);
   endtask

   task automatic test_reset_midword();
      cycle(1'b1, 8'hFF, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'h55, 1'b0);
      checks++;
      if ({x_out, x_valid, busy, in_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL midword_reset: got %b required 0001", {x_out, x_valid, busy, in_ready});
      end
      cycle(1'b1, 8'h81, 1'b1);
      checks++;
      if ({x_out, x_valid} !== 2'b11) begin
         errors++;
         $display("FAIL midword_restart: got x_out/x_valid=%b required 11", {x_out, x_valid});
      end
      for (int j = 0; j < PW; j++) begin
         cycle(1'b0, 8'h00, 1'b1);
         checks++;
         if ({x_out, x_valid, busy, in_ready} !== {m_x, m_v, m_v, m_r}) begin
            errors++;
            $display("FAIL midword_drain j=%0d: got %b required %b", j,
                     {x_out, x_valid, busy, in_ready}, {m_x, m_v, m_v, m_r});
         end
      end
      $display("test_reset_midword done");
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 49) != 0);
         checks++;
         if ({x_out, x_valid, busy, in_ready} !== {m_x, m_v, m_v, m_r}) begin
            errors++;
            $display("FAIL random k=%0d: got %b required %b", k,
                     {x_out, x_valid, busy, in_ready}, {m_x, m_v, m_v, m_r});
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_single(8'hA5);
`ifdef PISO_SERIALIZER_PARITY_EN
      test_single(8'h07);
      test_single(8'h03);
`endif
      test_back_to_back();
      test_backpressure();
      test_reset_midword();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
